// File: rtl/pkt_framer.sv
// Frames a payload stream into head / data / tail flits; head and tail are driven from registered state,
// data flits are a zero-latency pass-through, and every transfer waits on out_valid && out_ready.
module pkt_framer #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              start_ack,
  output logic              busy,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic              out_head,
  output logic              out_tail,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [7:0]        pkt_count
);

  typedef enum logic [1:0] {IDLE, HEAD, DATA, TAIL} state_t;

  state_t            state;
  logic [LEN_W-1:0]  rem;
  logic [DATA_W-1:0] chk;
  logic              out_fire;

  // rem still holds the requested length while in HEAD, so it doubles as the header value.
  always_comb begin
    out_valid = 1'b0;
    out_head  = 1'b0;
    out_tail  = 1'b0;
    out_data  = '0;
    in_ready  = 1'b0;
    case (state)
      HEAD: begin
        out_valid = 1'b1;
        out_head  = 1'b1;
        out_data  = DATA_W'(rem);
      end
      DATA: begin
        out_valid = in_valid;
        in_ready  = out_ready;
        out_data  = in_data;
      end
      TAIL: begin
        out_valid = 1'b1;
        out_tail  = 1'b1;
        out_data  = chk;
      end
      default: ;
    endcase
  end

  assign out_fire = out_valid && out_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rem       <= '0;
      chk       <= '0;
      pkt_count <= '0;
      start_ack <= 1'b0;
    end else begin
      start_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rem       <= len;
            chk       <= '0;
            start_ack <= 1'b1;
            state     <= HEAD;
          end
        end
        HEAD: begin
          if (out_fire) state <= (rem != '0) ? DATA : TAIL;
        end
        DATA: begin
          if (out_fire) begin
            chk <= chk ^ in_data;
            rem <= rem - LEN_W'(1);
            if (rem == LEN_W'(1)) state <= TAIL;
          end
        end
        TAIL: begin
          if (out_fire) begin
            pkt_count <= pkt_count + 8'd1;
            // A pending request is taken on the tail handshake so packets can run back to back.
            if (start) begin
              rem       <= len;
              chk       <= '0;
              start_ack <= 1'b1;
              state     <= HEAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_framer.sv
// Scoreboarded bench for pkt_framer: stimulus pushes expected flits, a negedge monitor pops and compares.
module tb_pkt_framer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] len;
  logic       start_ack;
  logic       busy;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_head;
  logic       out_tail;
  logic [7:0] out_data;
  logic       out_ready;
  logic [7:0] pkt_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] exp_q[$];
  logic [7:0] pl_q[$];
  logic [7:0] exp_cnt;

  pkt_framer #(.DATA_W(8), .LEN_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .start_ack(start_ack), .busy(busy),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_head(out_head), .out_tail(out_tail),
    .out_data(out_data), .out_ready(out_ready), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Expected flit for a packet: header = length, payload words, tail = xor of payload.
  task automatic push_packet(input int l, input logic [7:0] pl[$]);
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back({1'b1, 1'b0, 8'(l)});
    for (int i = 0; i < l; i++) begin
      exp_q.push_back({1'b0, 1'b0, pl[i]});
      x = x ^ pl[i];
    end
    exp_q.push_back({1'b0, 1'b1, x});
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_flit", {out_head, out_tail, out_data}, 32'h3ff);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("flit", {22'd0, out_head, out_tail, out_data}, {22'd0, e});
      end
    end
  end

  task automatic run_pkt(input int l, input bit rnd);
    logic [7:0] pl[$];
    int idx, cyc, rdy_seen;
    bit done;
    pl = pl_q;
    pl_q = {};
    while (pl.size() < l) pl.push_back(8'($urandom));
    push_packet(l, pl);
    start = 1'b1;
    len   = 4'(l);
    @(posedge clk); #1;
    start = 1'b0;
    check("start_ack", start_ack, 1'b1);
    idx = 0; cyc = 0; rdy_seen = 0; done = 0;
    while (!done && cyc < 400) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid  = (idx < l) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_data   = (idx < l) ? pl[idx] : 8'($urandom);
      @(negedge clk);
      if (in_ready) rdy_seen++;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready && out_tail) done = 1;
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("pkt_done", done, 1'b1);
    exp_cnt = exp_cnt + 8'd1;
    check("pkt_count", pkt_count, exp_cnt);
    check("busy_after_pkt", busy, 1'b0);
    if (!rnd) check("pkt_cycles", cyc, l + 2);
    if (l == 0) check("in_ready_len0", rdy_seen, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, ntail, cyc, tail_cyc, head2_cyc;
    logic [7:0] a, b, d0;
    logic [7:0] tmp_q[$];

    reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    exp_cnt = 8'd0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_start_ack", start_ack, 1'b0);
    check("rst_pkt_count", pkt_count, 8'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Nominal packet with fixed payload, then an empty packet.
    pl_q = '{8'h5A, 8'h3C};
    run_pkt(2, 1'b0);
    run_pkt(0, 1'b0);

    // Output stalls in HEAD and in DATA.
    a = 8'($urandom); b = 8'($urandom);
    tmp_q = '{a, b};
    push_packet(2, tmp_q);
    start = 1'b1; len = 4'd2;
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = a;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_head_valid", out_valid, 1'b1);
      check("stall_head_flags", {out_head, out_tail}, 2'b10);
      check("stall_head_data", out_data, 8'h02);
      check("stall_head_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_data_in_ready", in_ready, 1'b0);
      check("stall_data_flags", {out_valid, out_head, out_tail}, 3'b100);
      check("stall_data_data", out_data, a);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_data = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("stall_tail_flag", out_tail, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    check("stall_pkt_count", pkt_count, exp_cnt);

    // Start held across a tail handshake: len=1 then len=0 back to back.
    tmp_q = '{8'hA5};
    push_packet(1, tmp_q);
    tmp_q = {};
    push_packet(0, tmp_q);
    start = 1'b1; len = 4'd1; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    acks = 0; ntail = 0; cyc = 0; tail_cyc = -10; head2_cyc = -1;
    while (ntail < 2 && cyc < 50) begin
      @(negedge clk);
      if (start_ack) begin
        acks++;
        len = 4'd0;
        if (acks == 2) start = 1'b0;
      end
      if (out_valid && out_ready && out_head && acks == 2) head2_cyc = cyc;
      if (out_valid && out_ready && out_tail) begin
        ntail++;
        if (ntail == 1) tail_cyc = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_acks", acks, 2);
    check("b2b_head_follows_tail", head2_cyc, tail_cyc + 1);
    exp_cnt = exp_cnt + 8'd2;
    check("b2b_pkt_count", pkt_count, exp_cnt);

    // Random mix of lengths and stalls.
    for (int p = 0; p < 30; p++) run_pkt($urandom_range(0, 15), 1'b1);

    // Reset after the first of three data flits.
    d0 = 8'($urandom);
    exp_q.push_back({1'b1, 1'b0, 8'h03});
    exp_q.push_back({1'b0, 1'b0, d0});
    start = 1'b1; len = 4'd3;
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = d0;
    cyc = 0; ntail = 0;
    while (ntail == 0 && cyc < 20) begin
      @(negedge clk);
      if (in_valid && in_ready) ntail = 1;
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_mid_data_seen", ntail, 1);
    reset = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_in_ready", in_ready, 1'b0);
    check("rst_mid_start_ack", start_ack, 1'b0);
    check("rst_mid_pkt_count", pkt_count, 8'd0);
    check("rst_mid_flits_left", exp_q.size(), 0);
    exp_q = {};
    exp_cnt = 8'd0;
    @(posedge clk); #1;
    pl_q = '{8'hFF};
    run_pkt(1, 1'b0);

    // 256 full-length packets from a fresh reset: counter wraps back to zero.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_cnt = 8'd0;
    @(posedge clk); #1;
    for (int p = 0; p < 256; p++) run_pkt(15, 1'b1);
    check("wrap_pkt_count", pkt_count, 8'd0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pkt_framer.md
PKT_FRAMER -- requirements
Module: pkt_framer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning flit/payload data width (minimum 8).
REQ-002 SHALL have parameter LEN_W, default 4, meaning payload length field width (LEN_W <= DATA_W).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning reset; synchronous and active-high.
REQ-005 SHALL have port start, input, 1, meaning a request to frame one packet.
REQ-006 SHALL have port len, input, LEN_W, meaning payload flit count for the requested packet (0..2^LEN_W-1).
REQ-007 SHALL have port start_ack, output, 1, meaning a one-cycle pulse when start/len is accepted.
REQ-008 SHALL have port busy, output, 1, meaning state != IDLE.
REQ-009 SHALL have port in_valid, input, 1, meaning the payload word is valid.
REQ-010 SHALL have port in_data, input, DATA_W, meaning the payload word.
REQ-011 SHALL have port in_ready, output, 1, meaning the payload word is consumed this cycle.
REQ-012 SHALL have port out_valid, output, 1, meaning the flit is valid (consumed by the downstream head/data/tail receiver).
REQ-013 SHALL have port out_head, output, 1, meaning the flit is a head flit.
REQ-014 SHALL have port out_tail, output, 1, meaning the flit is a tail flit.
REQ-015 SHALL have port out_data, output, DATA_W, meaning the flit data.
REQ-016 SHALL have port out_ready, input, 1, meaning the downstream accepts the flit.
REQ-017 SHALL have port pkt_count, output, 8, meaning the number of completed packets, modulo 256.

Function
REQ-018 SHALL implement a state machine with four states: IDLE, HEAD, DATA, TAIL.
REQ-019 SHALL define a handshake as out_valid && out_ready in the same cycle; a flit SHALL transfer only on a handshake.
REQ-020 SHALL, in IDLE with start=1, latch len into rem, clear chk, pulse start_ack, and enter HEAD next cycle; start SHALL be ignored in HEAD and DATA.
REQ-021 SHALL, in HEAD, drive out_valid=1, out_head=1, out_tail=0, out_data=len zero-extended; on handshake go to DATA if rem!=0, else go to TAIL.
REQ-022 SHALL, in DATA, drive out_valid=in_valid, in_ready=out_ready, out_data=in_data, out_head=0, out_tail=0 (combinational pass-through, zero latency).
REQ-023 SHALL, in DATA on handshake, set chk <= chk ^ in_data and rem <= rem-1; when rem==1 it SHALL go to TAIL.
REQ-024 SHALL, in TAIL, drive out_valid=1, out_tail=1, out_data=chk; on handshake increment pkt_count (255 wraps to 0).
REQ-025 SHALL, on a TAIL handshake, go to IDLE if start=0; if start=1 it SHALL accept the new request in the same cycle (latch len, clear chk, pulse start_ack) and enter HEAD.
REQ-026 SHALL hold out_data/out_head/out_tail stable while out_valid=1 and out_ready=0 in HEAD and TAIL.
REQ-027 SHALL drive in_ready=0 in every state except DATA; out_valid, out_head, out_tail=0 and out_data=0 in IDLE.
REQ-028 SHALL NOT change rem, chk, or the state on a DATA cycle with in_valid=0 or out_ready=0.

Reset
REQ-029 SHALL, when reset=1 at a clk edge, set state=IDLE, rem=0, chk=0, and pkt_count=0; on the next cycle it SHALL drive out_valid=0, in_ready=0, start_ack=0 and busy=0.
REQ-030 SHALL give reset priority over start and over any handshake, including mid-packet; partial packets SHALL be abandoned without a tail.

Verification
REQ-031 SHALL verify: start, len=2, payload 0x5A,0x3C, out_ready=1 -> head 0x02, data 0x5A, data 0x3C, tail 0x66 on consecutive cycles, and pkt_count=1.
REQ-032 SHALL verify: start, len=0 -> head 0x00 then tail 0x00, in_ready never 1, and pkt_count increments by 1.
REQ-033 SHALL verify: out_ready=0 for 3 cycles in HEAD, then in DATA with in_valid=1 -> the flit is held stable, no payload is consumed, and rem/chk are unchanged.
REQ-034 SHALL verify: start held 1 across a TAIL handshake -> the next head follows in the very next cycle, start_ack pulses twice in total, and pkt_count=+2.
REQ-035 SHALL verify: reset=1 after 1 of 3 data flits -> the next cycle shows busy=0, out_valid=0, and pkt_count=0; a following len=1 packet with payload 0xFF SHALL frame as head 0x01, data 0xFF, tail 0xFF.
REQ-036 SHALL verify: 256 packets with len=15 -> each packet carries 15 data flits, and pkt_count wraps to 0.
